dec_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one 4-to-16 one-hot select line set between 16 requesters.
- Picks one requester and registers its 4-bit index.
- Drives the one-hot grant vector by decoding that index, and holds the grant until the requester releases it.
- Sits in front of the 4x16 decoder datapath, acting as its scheduler.

---
 rtl/dec_arb_pkg.sv | 14 +
 rtl/arb_rr_pick.sv | 26 ++
 rtl/dec_rr_arbiter.sv | 117 +++++++++++
 tb/tb_dec_rr_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dec_arb_pkg.sv
// Shared types and constants for the 16-way round-robin decoder arbiter.
package dec_arb_pkg;

  localparam int NREQ        = 16;
  localparam int IDXW        = 4;
  localparam int TMO_CYC_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    REL   = 2'd2
  } state_e;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module arb_rr_pick
  import dec_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [NREQ-1:0] hi;
  logic [NREQ-1:0] src;

  // Requests at or above ptr take precedence; otherwise fall back to the wrapped set.
  always_comb begin
    hi  = req & ({NREQ{1'b1}} << ptr);
    src = (|hi) ? hi : req;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (src[i]) idx = IDXW'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin scheduler for the 4x16 decoder: registered index, one-hot decoded grant.
// Optional forced release after TMO_CYC grant cycles when ARB_TIMEOUT_EN is defined.
module dec_rr_arbiter
  import dec_arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int TMO_CYC = TMO_CYC_DEF
)
`endif
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld
`ifdef ARB_TIMEOUT_EN
  ,
  output logic            tmo
`endif
);

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] win_idx;
  logic            win_any;
  logic            rel;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  arb_rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    rel     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = '0;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (en && win_any) begin
          state_d = GRANT;
          idx_d   = win_idx;
        end
      end
      GRANT: begin
        rel = done || !req[idx_q];
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
        if (!rel && (cnt_q == CNT_W'(TMO_CYC - 1))) begin
          rel   = 1'b1;
          tmo_d = 1'b1;
        end
`endif
        if (rel) begin
          state_d = REL;
          ptr_d   = idx_q + 1'b1;
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: reset wins over any in-flight release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Index and counter are only observed while granted, so they carry no reset.
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
`ifdef ARB_TIMEOUT_EN
    cnt_q <= cnt_d;
`endif
  end

  assign gnt_vld = (state_q == GRANT);
  assign gnt_idx = gnt_vld ? idx_q : '0;

  always_comb begin
    gnt = '0;
    if (gnt_vld) gnt[idx_q] = 1'b1;
  end

`ifdef ARB_TIMEOUT_EN
  assign tmo = tmo_q;
`endif

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Scoreboard bench for dec_rr_arbiter: directed vectors, expected grant order queued, monitor compares.
module tb_dec_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst, en, done;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;
`ifdef ARB_TIMEOUT_EN
  logic        tmo;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  dec_rr_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
`ifdef ARB_TIMEOUT_EN
    ,
    .tmo     (tmo)
`endif
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vld();
    for (int i = 0; i < 10 && !gnt_vld; i++) tick();
    check("wait_vld", gnt_vld, 1);
  endtask

  task automatic release_done();
    done = 1'b1;
    req  = 16'h0000;
    tick();
    done = 1'b0;
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each new grant.
  initial begin
    logic prev_vld;
    bit   had_gnt, rst_seen;
    int   zero_run, e;
    prev_vld = 1'b0;
    had_gnt  = 1'b0;
    rst_seen = 1'b0;
    zero_run = 0;
    forever begin
      @(negedge clk);
      if (rst) rst_seen = 1'b1;
      check("inv_onehot0", 32'($countones(gnt) <= 1), 1);
      check("inv_vld_eq_or", gnt_vld, |gnt);
      if (gnt_vld && !prev_vld) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got grant idx %0d, required no grant", gnt_idx);
        end else begin
          e = exp_q.pop_front();
          check("sb_idx", gnt_idx, e);
          check("sb_gnt", gnt, 32'(1) << e);
        end
        if (had_gnt && !rst_seen) check("gap_ge2", 32'(zero_run >= 2), 1);
        had_gnt  = 1'b1;
        rst_seen = 1'b0;
        zero_run = 0;
      end else if (!gnt_vld) begin
        zero_run++;
      end
      prev_vld = gnt_vld;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[5];
    rr_exp = '{0, 4, 15, 0, 4};
    rst = 1'b1; en = 1'b0; req = 16'h0; done = 1'b0;
    repeat (2) tick();
    check("rst_gnt", gnt, 0);
    check("rst_vld", gnt_vld, 0);
    check("rst_idx", gnt_idx, 0);
    rst = 1'b0;

    // Basic single grant, one-cycle latency, release spacing.
    en = 1'b1; req = 16'h0001; exp_q.push_back(0);
    tick();
    check("basic_lat_gnt", gnt, 16'h0001);
    check("basic_lat_idx", gnt_idx, 0);
    tick();
    check("basic_hold", gnt, 16'h0001);
    release_done();
    check("basic_rel_edge", gnt, 0);
    tick();
    check("basic_rel_dead", gnt, 0);
    req = 16'h0003; exp_q.push_back(1);
    wait_vld();
    check("basic_ptr1", gnt_idx, 1);
    release_done();

    // Reset mid-grant, then arbitration restarts from ptr 0.
    tick(); tick();
    req = 16'h0020; exp_q.push_back(5);
    wait_vld();
    check("mid_idx5", gnt_idx, 5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_vld", gnt_vld, 0);
    req = 16'h0021; exp_q.push_back(0);
    tick();
    check("mid_restart_vld", gnt_vld, 1);
    check("mid_restart_idx", gnt_idx, 0);
    release_done();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round-robin over 0, 4, 15 with wrap back to 0.
    req = 16'h8011;
    foreach (rr_exp[k]) exp_q.push_back(rr_exp[k]);
    for (int k = 0; k < 5; k++) begin
      wait_vld();
      check("rr_idx", gnt_idx, rr_exp[k]);
      tick();
      done = 1'b1;
      if (k == 4) req = 16'h0000;
      tick();
      done = 1'b0;
      check("rr_rel_edge", gnt, 0);
      tick();
      check("rr_rel_dead", gnt, 0);
    end

    // Drive ptr to 15, wrap search to 3, then release by withdrawal.
    req = 16'h4000; exp_q.push_back(14);
    wait_vld();
    release_done();
    req = 16'h0008; exp_q.push_back(3);
    wait_vld();
    check("wrap_idx3", gnt_idx, 3);
    req = 16'h0000;
    tick();
    check("withdraw_gnt", gnt, 0);
    req = 16'h0018; exp_q.push_back(4);
    wait_vld();
    check("withdraw_ptr4", gnt_idx, 4);
    release_done();

    // en=0 keeps a live grant but blocks new ones.
    req = 16'h0004; exp_q.push_back(2);
    wait_vld();
    check("en_idx2", gnt_idx, 2);
    en = 1'b0; req = 16'hFFFF;
    repeat (4) begin
      tick();
      check("en_hold_idx", gnt_idx, 2);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    check("en_rel", gnt, 0);
    repeat (6) begin
      tick();
      check("en_blocked", gnt_vld, 0);
    end
    en = 1'b1; exp_q.push_back(3);
    wait_vld();
    check("en_resume_idx", gnt_idx, 3);
    release_done();

`ifdef ARB_TIMEOUT_EN
    begin
      int n;
      tick(); tick();
      req = 16'h0080; exp_q.push_back(7);
      wait_vld();
      n = 1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (gnt == 16'h0080) n++;
        else break;
      end
      check("tmo_hold_cycles", n, 15);
      check("tmo_pulse", tmo, 1);
      check("tmo_gnt_drop", gnt, 0);
      req = 16'h0000;
      tick();
      check("tmo_pulse_end", tmo, 0);
      req = 16'h0080; exp_q.push_back(7);
      wait_vld();
      repeat (14) tick();
      check("tmo_c15_held", gnt, 16'h0080);
      release_done();
      check("tmo_done_wins", tmo, 0);
      check("tmo_done_gnt", gnt, 0);
    end
`endif

    repeat (3) tick();
    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
